// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register: hold, shift right/left, parallel load,
// saturating shift counter with a done pulse. Define USR_ROTATE_EN to add the rot port.
module universal_shift_reg #(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic [WIDTH-1:0] d,
`ifdef USR_ROTATE_EN
   input  logic             rot,
`endif
   output logic [WIDTH-1:0] q,
   output logic             sout_r,
   output logic             sout_l,
   output logic [CW-1:0]    cnt,
   output logic             done
);

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHR  = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

   localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] q_q, q_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             fill_r, fill_l;
   logic             shifted;

   always_comb begin
      fill_r  = sin_r;
      fill_l  = sin_l;
`ifdef USR_ROTATE_EN
      if (rot) begin
         fill_r = q_q[0];
         fill_l = q_q[WIDTH-1];
      end
`endif
      q_d     = q_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      shifted = 1'b0;
      if (en) begin
         case (mode_e'(mode))
            MODE_SHR: begin
               q_d     = {fill_r, q_q[WIDTH-1:1]};
               shifted = 1'b1;
            end
            MODE_SHL: begin
               q_d     = {q_q[WIDTH-2:0], fill_l};
               shifted = 1'b1;
            end
            MODE_LOAD: begin
               q_d   = d;
               cnt_d = '0;
            end
            default: ;
         endcase
      end
      // Counter saturates at WIDTH; done fires only on the WIDTH-1 -> WIDTH step.
      if (shifted && (cnt_q != CNT_MAX)) begin
         cnt_d  = cnt_q + 1'b1;
         done_d = (cnt_q == CNT_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q    <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign q      = q_q;
   assign cnt    = cnt_q;
   assign done   = done_q;
   assign sout_r = q_q[0];
   assign sout_l = q_q[WIDTH-1];

endmodule
